// File: rtl/branch_resolver_if.sv
// Decode/flag-side bundle for the branch resolver: branch request, flag
// issue/commit strobes, current flags, and the resolution outputs.
interface branch_resolver_if;
  logic        br_valid;
  logic [2:0]  br_ccc;
  logic [15:0] br_target;
  logic [15:0] pc_plus2;
  logic        iss_Z;
  logic        iss_N;
  logic        iss_V;
  logic        en_Z;
  logic        en_N;
  logic        en_V;
  logic        Z_flag;
  logic        N_flag;
  logic        V_flag;
  logic        stall;
  logic        br_done;
  logic        br_taken;
  logic [15:0] next_pc;
  logic        flush;
  logic        err;

  modport master (
    output br_valid, br_ccc, br_target, pc_plus2,
    output iss_Z, iss_N, iss_V, en_Z, en_N, en_V,
    output Z_flag, N_flag, V_flag,
    input  stall, br_done, br_taken, next_pc, flush, err
  );

  modport slave (
    input  br_valid, br_ccc, br_target, pc_plus2,
    input  iss_Z, iss_N, iss_V, en_Z, en_N, en_V,
    input  Z_flag, N_flag, V_flag,
    output stall, br_done, br_taken, next_pc, flush, err
  );
endinterface

// File: rtl/branch_resolver.sv
// Conditional branch resolver: stalls decode until every flag the branch
// depends on has no in-flight writer, then resolves taken/next_pc in one pulse.
module branch_resolver (
  input  logic            clk,
  input  logic            rst,
  branch_resolver_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    WAIT    = 2'd1,
    RESOLVE = 2'd2
  } state_t;

  localparam logic [2:0] CCC_NE     = 3'b000;
  localparam logic [2:0] CCC_EQ     = 3'b001;
  localparam logic [2:0] CCC_GT     = 3'b010;
  localparam logic [2:0] CCC_LT     = 3'b011;
  localparam logic [2:0] CCC_GTE    = 3'b100;
  localparam logic [2:0] CCC_LTE    = 3'b101;
  localparam logic [2:0] CCC_OVFL   = 3'b110;

  state_t      state_reg;
  state_t      state_next;
  logic [2:0]  ccc_reg;
  logic [15:0] target_reg;
  logic [15:0] fall_reg;
  logic        err_reg;

  // Flag vectors are ordered {V, N, Z}.
  logic [2:0] iss;
  logic [2:0] en;
  logic [2:0] pend_zero;
  logic [2:0] cnt_fault;
  logic [2:0] need;
  logic       ready;
  logic       cond;

  assign iss = {bus.iss_V, bus.iss_N, bus.iss_Z};
  assign en  = {bus.en_V,  bus.en_N,  bus.en_Z};

  for (genvar gi = 0; gi < 3; gi++) begin : g_cnt
    logic [1:0] cnt_reg;
    logic [1:0] cnt_next;
    logic       fault;

    always_comb begin
      cnt_next = cnt_reg;
      fault    = 1'b0;
      if (iss[gi] && !en[gi]) begin
        if (cnt_reg == 2'd3) fault = 1'b1;
        else                 cnt_next = cnt_reg + 2'd1;
      end else if (en[gi] && !iss[gi]) begin
        if (cnt_reg == 2'd0) fault = 1'b1;
        else                 cnt_next = cnt_reg - 2'd1;
      end
    end

    always_ff @(posedge clk or posedge rst) begin
      if (rst) cnt_reg <= 2'd0;
      else     cnt_reg <= cnt_next;
    end

    assign pend_zero[gi] = (cnt_reg == 2'd0);
    assign cnt_fault[gi] = fault;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)             err_reg <= 1'b0;
    else if (|cnt_fault) err_reg <= 1'b1;
  end

  always_comb begin
    need = 3'b000;
    case (ccc_reg)
      CCC_NE, CCC_EQ:          need = 3'b001;
      CCC_LT:                  need = 3'b010;
      CCC_GT, CCC_GTE, CCC_LTE: need = 3'b011;
      CCC_OVFL:                need = 3'b100;
      default:                 need = 3'b000;
    endcase
  end

  assign ready = ((need & ~pend_zero) == 3'b000);

  // Flags are sampled live in RESOLVE; by then every required writer has committed.
  always_comb begin
    cond = 1'b1;
    case (ccc_reg)
      CCC_NE:   cond = !bus.Z_flag;
      CCC_EQ:   cond = bus.Z_flag;
      CCC_GT:   cond = !bus.Z_flag && !bus.N_flag;
      CCC_LT:   cond = bus.N_flag;
      CCC_GTE:  cond = bus.Z_flag || !bus.N_flag;
      CCC_LTE:  cond = bus.Z_flag || bus.N_flag;
      CCC_OVFL: cond = bus.V_flag;
      default:  cond = 1'b1;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_reg <= IDLE;
    else     state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (bus.br_valid) state_next = WAIT;
      WAIT:    if (ready)        state_next = RESOLVE;
      RESOLVE: state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ccc_reg    <= 3'd0;
      target_reg <= 16'd0;
      fall_reg   <= 16'd0;
    end else if (state_reg == IDLE && bus.br_valid) begin
      ccc_reg    <= bus.br_ccc;
      target_reg <= bus.br_target;
      fall_reg   <= bus.pc_plus2;
    end
  end

  always_comb begin
    bus.stall    = (state_reg != IDLE);
    bus.br_done  = 1'b0;
    bus.br_taken = 1'b0;
    bus.next_pc  = 16'd0;
    bus.flush    = 1'b0;
    bus.err      = err_reg;
    if (state_reg == RESOLVE) begin
      bus.br_done  = 1'b1;
      bus.br_taken = cond;
      bus.next_pc  = cond ? target_reg : fall_reg;
      bus.flush    = cond;
    end
  end

endmodule

// File: tb/tb_branch_resolver.sv
// Bench for branch_resolver: directed scenarios then randomized traffic,
// all checked every cycle against a behavioural model of the resolver.
module tb_branch_resolver;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  branch_resolver_if bus();
  branch_resolver dut (.clk(clk), .rst(rst), .bus(bus));

  int errors = 0;
  int checks = 0;

  // Model: pending-write counts per flag {Z,N,V}, branch bookkeeping.
  int          m_cnt [3];
  bit          m_err;
  bit          m_busy;
  bit          m_fire;
  logic [2:0]  m_ccc;
  logic [15:0] m_tgt;
  logic [15:0] m_fall;

  logic        obs_done;
  logic        obs_stall;
  logic        obs_taken;
  logic [15:0] obs_pc;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic bit cond_met(input logic [2:0] ccc, input bit z, input bit n, input bit v);
    case (ccc)
      3'd0: return !z;
      3'd1: return z;
      3'd2: return !z && !n;
      3'd3: return n;
      3'd4: return z || !n;
      3'd5: return z || n;
      3'd6: return v;
      default: return 1'b1;
    endcase
  endfunction

  function automatic bit flags_settled(input logic [2:0] ccc);
    bit uz, un, uv;
    uz = (ccc == 3'd0) || (ccc == 3'd1) || (ccc == 3'd2) || (ccc == 3'd4) || (ccc == 3'd5);
    un = (ccc == 3'd2) || (ccc == 3'd3) || (ccc == 3'd4) || (ccc == 3'd5);
    uv = (ccc == 3'd6);
    return !(uz && m_cnt[0] != 0) && !(un && m_cnt[1] != 0) && !(uv && m_cnt[2] != 0);
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 3; i++) m_cnt[i] = 0;
    m_err = 0; m_busy = 0; m_fire = 0;
    m_ccc = '0; m_tgt = '0; m_fall = '0;
  endtask

  task automatic model_clock();
    bit is [3];
    bit cm [3];
    is[0] = bus.iss_Z; is[1] = bus.iss_N; is[2] = bus.iss_V;
    cm[0] = bus.en_Z;  cm[1] = bus.en_N;  cm[2] = bus.en_V;
    // Branch progress uses counts as they stood before this edge.
    if (m_fire) begin
      m_fire = 0; m_busy = 0;
    end else if (m_busy) begin
      if (flags_settled(m_ccc)) m_fire = 1;
    end else if (bus.br_valid) begin
      m_busy = 1;
      m_ccc = bus.br_ccc; m_tgt = bus.br_target; m_fall = bus.pc_plus2;
    end
    for (int i = 0; i < 3; i++) begin
      if (is[i] && !cm[i]) begin
        if (m_cnt[i] == 3) m_err = 1; else m_cnt[i]++;
      end else if (cm[i] && !is[i]) begin
        if (m_cnt[i] == 0) m_err = 1; else m_cnt[i]--;
      end
    end
  endtask

  task automatic cycle();
    bit          t;
    logic [15:0] pc;
    @(negedge clk);
    t  = m_fire && cond_met(m_ccc, bus.Z_flag, bus.N_flag, bus.V_flag);
    pc = !m_fire ? 16'h0 : (t ? m_tgt : m_fall);
    obs_done = bus.br_done; obs_stall = bus.stall;
    obs_taken = bus.br_taken; obs_pc = bus.next_pc;
    check_eq("stall", bus.stall, m_busy);
    check_eq("br_done", bus.br_done, m_fire);
    check_eq("br_taken", bus.br_taken, t);
    check_eq("next_pc", bus.next_pc, pc);
    check_eq("flush", bus.flush, t);
    check_eq("err", bus.err, m_err);
    if (bus.br_done)
      $display("branch: t=%0t ccc=%0d taken=%0b next_pc=%04h", $time, m_ccc, bus.br_taken, bus.next_pc);
    @(posedge clk);
    model_clock();
    #1;
  endtask

  task automatic idle_inputs();
    bus.br_valid = 0;
    bus.iss_Z = 0; bus.iss_N = 0; bus.iss_V = 0;
    bus.en_Z = 0;  bus.en_N = 0;  bus.en_V = 0;
  endtask

  task automatic do_reset();
    idle_inputs();
    @(negedge clk);
    #1 rst = 1;
    #1;
    check_eq("rst_stall", bus.stall, 0);
    check_eq("rst_done", bus.br_done, 0);
    check_eq("rst_flush", bus.flush, 0);
    check_eq("rst_err", bus.err, 0);
    model_reset();
    #1 rst = 0;
    @(posedge clk);
    #1;
  endtask

  initial begin
    idle_inputs();
    bus.br_ccc = 0; bus.br_target = 0; bus.pc_plus2 = 0;
    bus.Z_flag = 0; bus.N_flag = 0; bus.V_flag = 0;
    model_reset();
    #12;
    check_eq("init_stall", bus.stall, 0);
    check_eq("init_done", bus.br_done, 0);
    check_eq("init_pc", bus.next_pc, 0);
    @(negedge clk);
    rst = 0;
    @(posedge clk);
    #1;

    // Unconditional, nothing pending: done two cycles after br_valid.
    bus.br_valid = 1; bus.br_ccc = 3'd7; bus.br_target = 16'h0040; bus.pc_plus2 = 16'h0022;
    cycle();
    bus.br_valid = 0;
    cycle();
    check_eq("uncond_stall_c1", obs_stall, 1);
    cycle();
    check_eq("uncond_done_c2", obs_done, 1);
    check_eq("uncond_pc_c2", obs_pc, 16'h0040);
    check_eq("uncond_stall_c2", obs_stall, 1);

    // EQ waits on an in-flight Z writer.
    bus.iss_Z = 1;
    cycle();
    bus.iss_Z = 0; bus.br_valid = 1; bus.br_ccc = 3'd1; bus.br_target = 16'h1234; bus.pc_plus2 = 16'h0100;
    cycle();
    bus.br_valid = 0;
    cycle(); cycle();
    bus.en_Z = 1; bus.Z_flag = 1;
    cycle();
    bus.en_Z = 0;
    cycle();
    check_eq("eq_wait_done", obs_done, 0);
    check_eq("eq_wait_stall", obs_stall, 1);
    cycle();
    check_eq("eq_done", obs_done, 1);
    check_eq("eq_taken", obs_taken, 1);
    check_eq("eq_pc", obs_pc, 16'h1234);

    // GT not taken falls through.
    bus.Z_flag = 0; bus.N_flag = 1;
    bus.br_valid = 1; bus.br_ccc = 3'd2; bus.br_target = 16'h0099; bus.pc_plus2 = 16'h0012;
    cycle();
    bus.br_valid = 0;
    cycle(); cycle();
    check_eq("gt_done", obs_done, 1);
    check_eq("gt_taken", obs_taken, 0);
    check_eq("gt_pc", obs_pc, 16'h0012);

    // Simultaneous V issue and commit leaves pv at 1; OVFL keeps waiting.
    bus.iss_V = 1;
    cycle();
    bus.en_V = 1;
    cycle();
    bus.iss_V = 0; bus.en_V = 0;
    bus.br_valid = 1; bus.br_ccc = 3'd6; bus.br_target = 16'h0A0A; bus.V_flag = 1;
    cycle();
    bus.br_valid = 0;
    for (int i = 0; i < 4; i++) cycle();
    check_eq("ovfl_hold_stall", obs_stall, 1);
    check_eq("ovfl_hold_done", obs_done, 0);
    bus.en_V = 1;
    cycle();
    bus.en_V = 0;
    cycle(); cycle();
    check_eq("ovfl_done", obs_done, 1);
    check_eq("ovfl_pc", obs_pc, 16'h0A0A);

    // Counter overflow is sticky until reset.
    bus.iss_N = 1;
    for (int i = 0; i < 4; i++) cycle();
    bus.iss_N = 0;
    cycle();
    check_eq("pn_ovf_err", bus.err, 1);
    do_reset();
    cycle();
    check_eq("pn_rst_err", bus.err, 0);

    // Reset while waiting abandons the branch.
    bus.iss_Z = 1;
    cycle();
    bus.iss_Z = 0; bus.br_valid = 1; bus.br_ccc = 3'd0;
    cycle();
    bus.br_valid = 0;
    cycle();
    check_eq("abandon_pre_stall", obs_stall, 1);
    do_reset();
    for (int i = 0; i < 5; i++) begin
      cycle();
      check_eq("abandon_done", obs_done, 0);
    end

    // Randomized traffic.
    for (int n = 0; n < 1500; n++) begin
      bus.br_valid  = ($urandom_range(0, 3) == 0);
      bus.br_ccc    = 3'($urandom_range(0, 7));
      bus.br_target = 16'($urandom);
      bus.pc_plus2  = 16'($urandom);
      bus.Z_flag = $urandom_range(0, 1) == 1;
      bus.N_flag = $urandom_range(0, 1) == 1;
      bus.V_flag = $urandom_range(0, 1) == 1;
      bus.iss_Z = ($urandom_range(0, 5) == 0);
      bus.iss_N = ($urandom_range(0, 5) == 0);
      bus.iss_V = ($urandom_range(0, 7) == 0);
      bus.en_Z = (m_cnt[0] > 0) ? ($urandom_range(0, 2) == 0) : ($urandom_range(0, 60) == 0);
      bus.en_N = (m_cnt[1] > 0) ? ($urandom_range(0, 2) == 0) : ($urandom_range(0, 60) == 0);
      bus.en_V = (m_cnt[2] > 0) ? ($urandom_range(0, 2) == 0) : ($urandom_range(0, 60) == 0);
      if ($urandom_range(0, 150) == 0) do_reset();
      else cycle();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/branch_resolver.md
BRANCH_RESOLVER -- requirements
Module: branch_resolver

Interface
REQ-001 SHALL have no parameters; all widths are fixed as listed.
REQ-002 clk  input  1  single clock for all state, rising edge.
REQ-003 rst  input  1  asynchronous, active-high reset.
REQ-004 br_valid  input  1  branch presented by decode; sampled only in IDLE.
REQ-005 br_ccc  input  3  condition code: 000 NE, 001 EQ, 010 GT, 011 LT, 100 GTE, 101 LTE, 110 OVFL, 111 UNCOND.
REQ-006 br_target  input  16  taken target PC.
REQ-007 pc_plus2  input  16  fall-through PC.
REQ-008 iss_Z, iss_N, iss_V  input  1 each  flag-setting instruction issued (one pulse per instruction per flag it writes).
REQ-009 en_Z, en_N, en_V  input  1 each  flag write committing this cycle (same strobes as flag register write enables).
REQ-010 Z_flag, N_flag, V_flag  input  1 each  current flag register outputs.
REQ-011 stall  output  1  hold fetch/decode.
REQ-012 br_done  output  1  one-cycle resolution pulse.
REQ-013 br_taken  output  1  branch taken; valid only with br_done.
REQ-014 next_pc  output  16  redirect PC; valid only with br_done.
REQ-015 flush  output  1  squash younger instructions; equals br_done & br_taken.
REQ-016 err  output  1  sticky pending-counter overflow indicator.

Function
REQ-017 SHALL keep one 2-bit pending counter per flag (pz, pn, pv).
REQ-018 Per counter each cycle: issue only -> +1; commit only -> -1; both or neither -> unchanged.
REQ-019 Issue at count 3 without commit SHALL hold 3 and set err; commit at count 0 without issue SHALL hold 0 and set err.
REQ-020 Required flags per ccc: NE/EQ -> Z; LT -> N; GT/GTE/LTE -> Z and N; OVFL -> V; UNCOND -> none.
REQ-021 FSM states: IDLE, WAIT, RESOLVE.
REQ-022 IDLE: on br_valid, register br_ccc, br_target and pc_plus2, then go to WAIT; otherwise remain in IDLE.
REQ-023 WAIT: go to RESOLVE when the registered counters of all required flags are 0; otherwise remain in WAIT.
REQ-024 RESOLVE: assert br_done for exactly one cycle, then go to IDLE.
REQ-025 stall SHALL be 1 whenever state is not IDLE, and 0 in IDLE, including the cycle br_valid is sampled.
REQ-026 Conditions, evaluated in RESOLVE from Z_flag/N_flag/V_flag:
  - NE: !Z
  - EQ: Z
  - GT: !Z & !N
  - LT: N
  - GTE: Z | !N
  - LTE: Z | N
  - OVFL: V
  - UNCOND: 1
REQ-027 next_pc SHALL be the captured target if taken, else the captured pc_plus2.
REQ-028 br_valid outside IDLE SHALL be ignored, and captured fields SHALL NOT change.
REQ-029 Minimum latency, br_valid to br_done, is 2 cycles (zero pending); each extra WAIT cycle adds 1.
REQ-030 Counters SHALL update in every state, independent of the FSM.
REQ-031 br_taken, next_pc and flush SHALL be 0 when br_done is 0.

Reset
REQ-032 rst SHALL asynchronously force:
  - state to IDLE
  - all counters to 0
  - err to 0
  - captured registers to 0
  - all outputs to 0
REQ-033 rst asserted during WAIT or RESOLVE SHALL abandon the branch with no br_done or flush pulse.

Verification
REQ-034 ccc=111, no pending, br_valid at cycle 0, target 0x0040 -> br_done=1, br_taken=1, next_pc=0x0040, flush=1 at cycle 2; stall=1 in cycles 1-2.
REQ-035 iss_Z at cycle 0, then EQ branch at cycle 1, en_Z with Z_in=1 at cycle 4 -> stall held through WAIT; br_done when pz returns to 0; Z_flag=1 so br_taken=1.
REQ-036 ccc=010 (GT), Z_flag=0, N_flag=1, pc_plus2=0x0012 -> br_taken=0, next_pc=0x0012, flush=0, br_done=1.
REQ-037 pv=1 with iss_V and en_V in the same cycle -> pv stays 1, and an OVFL branch keeps waiting.
REQ-038 Four iss_N pulses with no commit -> pn=3, err=1; rst -> pn=0, err=0.
REQ-039 rst pulsed while in WAIT -> state IDLE, stall=0, and no br_done/flush on any later cycle until a new br_valid.
